// File: rtl/sck_ctrl_pkg.sv
// Shared types and helpers for the SCK control sequencer: state encoding,
// condition codes, flag bit positions and instruction field offsets.
package sck_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_STALL,
      ST_EXEC,
      ST_DONE
   } state_e;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_NZ     = 2'b10;
   localparam logic [1:0] COND_N      = 2'b11;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;

   // Register fields are packed from the MSB downwards: src0, src1, dst.
   function automatic int unsigned src0_msb(input int unsigned instr_w);
      return instr_w - 1;
   endfunction

   function automatic int unsigned src1_msb(input int unsigned instr_w, input int unsigned reg_w);
      return instr_w - 1 - reg_w;
   endfunction

   function automatic int unsigned dst_msb(input int unsigned instr_w, input int unsigned reg_w);
      return instr_w - 1 - 2 * reg_w;
   endfunction

   function automatic logic cond_pass(input logic [1:0] cond, input logic z, input logic n);
      case (cond)
         COND_ALWAYS: return 1'b1;
         COND_Z:      return z;
         COND_NZ:     return !z;
         default:     return n;
      endcase
   endfunction

endpackage

// File: rtl/sck_ctrl_fsm_if.sv
// Instruction / result handshake bundle between the SCK control FSM (slave)
// and its environment (master): upstream issue, instruction register, flags, result.
interface sck_ctrl_fsm_if #(
   parameter int unsigned INSTR_W = 25,
   parameter int unsigned REG_W   = 4
);
   logic               i_valid;
   logic               o_ready;
   logic [INSTR_W-1:0] i_instr;
   logic               o_instr_save;
   logic [INSTR_W-1:0] i_instr_reg;
   logic [3:0]         i_flags;
   logic [REG_W-1:0]   o_reg0;
   logic [REG_W-1:0]   o_reg1;
   logic [REG_W-1:0]   o_dst;
   logic               o_exec_en;
   logic               o_exec_first;
   logic               o_stall;
   logic               o_skip;
   logic               o_valid;
   logic               i_ready;

   modport slave (
      input  i_valid, i_instr, i_instr_reg, i_flags, i_ready,
      output o_ready, o_instr_save, o_reg0, o_reg1, o_dst,
             o_exec_en, o_exec_first, o_stall, o_skip, o_valid
   );

   modport master (
      output i_valid, i_instr, i_instr_reg, i_flags, i_ready,
      input  o_ready, o_instr_save, o_reg0, o_reg1, o_dst,
             o_exec_en, o_exec_first, o_stall, o_skip, o_valid
   );
endinterface

// File: rtl/sck_hazard_unit.sv
// Tracks the destination of the most recently retired result for WB_LAT cycles
// and flags a read-after-write hazard when either source matches it.
module sck_hazard_unit #(
   parameter int unsigned REG_W  = 4,
   parameter int unsigned WB_LAT = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [REG_W-1:0] i_load_dst,
   input  logic [REG_W-1:0] i_src0,
   input  logic [REG_W-1:0] i_src1,
   output logic             o_hazard
);

   localparam int unsigned      CNT_W    = (WB_LAT < 1) ? 1 : $clog2(WB_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WB_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
   logic [REG_W-1:0] pend_dst_q, pend_dst_d;

   // A fresh load takes priority over the running decrement.
   always_comb begin
      pend_cnt_d = pend_cnt_q;
      pend_dst_d = pend_dst_q;
      if (i_load) begin
         pend_cnt_d = CNT_INIT;
         pend_dst_d = i_load_dst;
      end else if (pend_cnt_q != '0) begin
         pend_cnt_d = pend_cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_cnt_q <= '0;
         pend_dst_q <= '0;
      end else begin
         pend_cnt_q <= pend_cnt_d;
         pend_dst_q <= pend_dst_d;
      end
   end

   assign o_hazard = (pend_cnt_q != '0) &&
                     ((i_src0 == pend_dst_q) || (i_src1 == pend_dst_q));

endmodule

// File: rtl/sck_ctrl_fsm.sv
// SCK communication unit control FSM: accepts one instruction per handshake,
// checks hazards and condition, runs a multi-cycle EXEC phase and holds the result.
module sck_ctrl_fsm
   import sck_ctrl_pkg::*;
#(
   parameter int unsigned INSTR_W     = 25,
   parameter int unsigned REG_W       = 4,
   parameter int unsigned EXEC_CYCLES = 3,
   parameter int unsigned WB_LAT      = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   sck_ctrl_fsm_if.slave bus
);

   if (INSTR_W < 3 * REG_W + 2) begin : g_bad_instr_w
      $error("INSTR_W too small for three register fields plus a condition code");
   end
   if (EXEC_CYCLES < 1) begin : g_bad_exec
      $error("EXEC_CYCLES must be at least 1");
   end

   localparam int unsigned SRC0_MSB = src0_msb(INSTR_W);
   localparam int unsigned SRC1_MSB = src1_msb(INSTR_W, REG_W);
   localparam int unsigned DST_MSB  = dst_msb(INSTR_W, REG_W);

   localparam int unsigned       ECNT_W    = (EXEC_CYCLES <= 1) ? 1 : $clog2(EXEC_CYCLES);
   localparam logic [ECNT_W-1:0] EXEC_LOAD = ECNT_W'(EXEC_CYCLES - 1);
   localparam logic [ECNT_W-1:0] ECNT_ONE  = ECNT_W'(1);

   state_e            state_q, state_d;
   logic [ECNT_W-1:0] exec_cnt_q, exec_cnt_d;

   logic [REG_W-1:0] src0, src1, dst;
   logic [1:0]       cond;
   logic             cond_ok;
   logic             hazard;
   logic             retire;

   logic ready, save, exec_en, exec_first, stall, skip, valid;

   assign src0    = bus.i_instr_reg[SRC0_MSB -: REG_W];
   assign src1    = bus.i_instr_reg[SRC1_MSB -: REG_W];
   assign dst     = bus.i_instr_reg[DST_MSB  -: REG_W];
   assign cond    = bus.i_instr_reg[1:0];
   assign cond_ok = cond_pass(cond, bus.i_flags[FLAG_Z], bus.i_flags[FLAG_N]);

   // Only the field extraction uses the instruction register; the raw bus is handshake-only.
   logic unused_in;
   assign unused_in = ^{bus.i_instr, bus.i_instr_reg[DST_MSB-REG_W:2], bus.i_flags[3:2]};

   sck_hazard_unit #(
      .REG_W  (REG_W),
      .WB_LAT (WB_LAT)
   ) u_hazard (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (retire),
      .i_load_dst (dst),
      .i_src0     (src0),
      .i_src1     (src1),
      .o_hazard   (hazard)
   );

   always_comb begin
      state_d    = state_q;
      exec_cnt_d = exec_cnt_q;
      ready      = 1'b0;
      save       = 1'b0;
      exec_en    = 1'b0;
      exec_first = 1'b0;
      stall      = 1'b0;
      skip       = 1'b0;
      valid      = 1'b0;
      retire     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (bus.i_valid) begin
               save    = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE, ST_STALL: begin
            if (hazard) begin
               stall   = 1'b1;
               state_d = ST_STALL;
            end else if (!cond_ok) begin
               skip    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               exec_cnt_d = EXEC_LOAD;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            exec_en    = 1'b1;
            exec_first = (exec_cnt_q == EXEC_LOAD);
            if (exec_cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               exec_cnt_d = exec_cnt_q - ECNT_ONE;
            end
         end
         ST_DONE: begin
            valid = 1'b1;
            if (bus.i_ready) begin
               retire  = !i_rst;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         exec_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         exec_cnt_q <= exec_cnt_d;
      end
   end

   // Reset forces every output low, independent of the state register contents.
   assign bus.o_ready      = ready      & ~i_rst;
   assign bus.o_instr_save = save       & ~i_rst;
   assign bus.o_exec_en    = exec_en    & ~i_rst;
   assign bus.o_exec_first = exec_first & ~i_rst;
   assign bus.o_stall      = stall      & ~i_rst;
   assign bus.o_skip       = skip       & ~i_rst;
   assign bus.o_valid      = valid      & ~i_rst;
   assign bus.o_reg0       = i_rst ? '0 : src0;
   assign bus.o_reg1       = i_rst ? '0 : src1;
   assign bus.o_dst        = i_rst ? '0 : dst;

endmodule

// File: tb/tb_sck_ctrl_fsm.sv
// Self-checking bench for sck_ctrl_fsm: directed table, multi-cycle corner
// sequences and random traffic against a transaction-timing reference model.
module tb_sck_ctrl_fsm;

   localparam int unsigned INSTR_W = 25;
   localparam int unsigned REG_W   = 4;
   localparam int          E       = 3;
   localparam int          WB      = 2;

   localparam logic [6:0] CTL_IDLE  = 7'b1000000;
   localparam logic [6:0] CTL_ACC   = 7'b1100000;
   localparam logic [6:0] CTL_EX    = 7'b0010000;
   localparam logic [6:0] CTL_EXF   = 7'b0011000;
   localparam logic [6:0] CTL_STALL = 7'b0000100;
   localparam logic [6:0] CTL_SKIP  = 7'b0000010;
   localparam logic [6:0] CTL_DONE  = 7'b0000001;
   localparam logic [6:0] CTL_NONE  = 7'b0000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sck_ctrl_fsm_if #(.INSTR_W(INSTR_W), .REG_W(REG_W)) bus ();

   sck_ctrl_fsm #(
      .INSTR_W     (INSTR_W),
      .REG_W       (REG_W),
      .EXEC_CYCLES (E),
      .WB_LAT      (WB)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Environment-side instruction register, written on o_instr_save.
   logic [INSTR_W-1:0] ireg_q = '0;
   always @(posedge clk) if (bus.o_instr_save) ireg_q <= bus.i_instr;
   assign bus.i_instr_reg = ireg_q;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: cycle of the last result handshake and its destination.
   int         last_h   = -1000;
   logic [3:0] pend_dst = '0;

   typedef struct {
      logic [INSTR_W-1:0] instr;
      logic [3:0]         flags;
      logic [11:0]        exp_fields;
      bit                 exp_exec;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] ctl();
      return {bus.o_ready, bus.o_instr_save, bus.o_exec_en, bus.o_exec_first,
              bus.o_stall, bus.o_skip, bus.o_valid};
   endfunction

   function automatic bit cond_true(input logic [1:0] c, input logic [3:0] f);
      case (c)
         2'b00:   return 1'b1;
         2'b01:   return f[0];
         2'b10:   return !f[0];
         default: return f[1];
      endcase
   endfunction

   function automatic logic [INSTR_W-1:0] mk(input logic [3:0] s0, input logic [3:0] s1,
                                             input logic [3:0] d, input logic [10:0] mid,
                                             input logic [1:0] c);
      return {s0, s1, d, mid, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   // Drives one instruction through its whole life, checking every cycle against
   // the timing predicted from the accept cycle, hazard window and condition.
   task automatic run_txn(input logic [INSTR_W-1:0] instr, input logic [3:0] flags,
                          input int r, input int gap, input bit noise,
                          output bit saw_valid, output int n_stall, output int valid_off,
                          output logic [11:0] fields);
      logic [3:0] s0, s1, dd;
      int c, d;
      bit take;
      s0 = instr[INSTR_W-1 -: 4];
      s1 = instr[INSTR_W-5 -: 4];
      dd = instr[INSTR_W-9 -: 4];
      saw_valid = 1'b0;
      n_stall   = 0;
      valid_off = -1;
      fields    = '0;
      bus.i_instr = instr;
      bus.i_flags = flags;
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      samp();
      chk("accept", 32'(ctl()), 32'(CTL_ACC));
      c = cyc;
      tick();
      bus.i_valid = noise;
      d = c + 1;
      while (d <= last_h + WB && (s0 == pend_dst || s1 == pend_dst)) d++;
      take = cond_true(instr[1:0], flags);
      while (cyc <= d) begin
         samp();
         if (cyc == c + 1) begin
            fields = {bus.o_reg0, bus.o_reg1, bus.o_dst};
            chk("decode_fields", 32'(fields), 32'({s0, s1, dd}));
         end
         n_stall += int'(bus.o_stall);
         if (cyc < d) chk("stall", 32'(ctl()), 32'(CTL_STALL));
         else         chk("decide", 32'(ctl()), 32'(take ? CTL_NONE : CTL_SKIP));
         tick();
      end
      if (take) begin
         for (int e = 1; e <= E; e++) begin
            samp();
            chk("exec", 32'(ctl()), 32'((e == 1) ? CTL_EXF : CTL_EX));
            tick();
         end
         for (int k = 0; k <= r; k++) begin
            bus.i_ready = (k == r);
            samp();
            if (bus.o_valid && !saw_valid) begin
               saw_valid = 1'b1;
               valid_off = cyc - c;
            end
            chk("done", 32'(ctl()), 32'(CTL_DONE));
            chk("dst_hold", 32'(bus.o_dst), 32'(dd));
            if (k == r) begin
               last_h   = cyc;
               pend_dst = dd;
            end
            tick();
         end
      end
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         samp();
         chk("idle", 32'(ctl()), 32'(CTL_IDLE));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          saw;
      int          ns, voff;
      logic [11:0] flds;

      tbl[0] = '{25'h0246000, 4'b0000, 12'h123, 1'b1};
      tbl[1] = '{25'h08AC001, 4'b0000, 12'h456, 1'b0};
      tbl[2] = '{25'h08AC001, 4'b0001, 12'h456, 1'b1};
      tbl[3] = '{25'h1E14002, 4'b1100, 12'hF0A, 1'b1};
      tbl[4] = '{25'h1E14002, 4'b0001, 12'hF0A, 1'b0};
      tbl[5] = '{25'h0F12003, 4'b0010, 12'h789, 1'b1};
      tbl[6] = '{25'h0F12003, 4'b1101, 12'h789, 1'b0};
      tbl[7] = '{25'h059DFFC, 4'b0000, 12'h2CE, 1'b1};

      bus.i_valid = 1'b1;
      bus.i_instr = 25'h1FFFFFF;
      bus.i_flags = '0;
      bus.i_ready = 1'b1;
      rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         samp();
         chk("rst_ctl", 32'(ctl()), 32'(CTL_NONE));
         chk("rst_fields", 32'({bus.o_reg0, bus.o_reg1, bus.o_dst}), 32'(0));
         tick();
      end
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      samp();
      chk("post_rst_ready", 32'(ctl()), 32'(CTL_IDLE));
      tick();

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].instr, tbl[i].flags, 0, 1, 1'b0, saw, ns, voff, flds);
         chk("tbl_fields", 32'(flds), 32'(tbl[i].exp_fields));
         chk("tbl_exec", 32'(saw), 32'(tbl[i].exp_exec));
         if (tbl[i].exp_exec) chk("tbl_latency", 32'(voff), 32'(E + 2));
      end

      // Back-pressure: result held for five cycles, one handshake at the end.
      run_txn(25'h0246000, 4'b0000, 4, 1, 1'b1, saw, ns, voff, flds);
      chk("bp_latency", 32'(voff), 32'(E + 2));

      // RAW hazard right after retirement, then the same spacing without a match.
      run_txn(25'h024A000, 4'b0000, 0, 0, 1'b0, saw, ns, voff, flds);
      run_txn(25'h0A02000, 4'b0000, 0, 1, 1'b0, saw, ns, voff, flds);
      chk("haz_stall_cnt", 32'(ns), 32'(1));
      chk("haz_latency", 32'(voff), 32'(E + 3));
      run_txn(25'h024A000, 4'b0000, 0, 0, 1'b0, saw, ns, voff, flds);
      run_txn(25'h0C02000, 4'b0000, 0, 1, 1'b0, saw, ns, voff, flds);
      chk("nohaz_stall_cnt", 32'(ns), 32'(0));

      // Reset during EXEC abandons the instruction.
      bus.i_instr = 25'h066E000;
      bus.i_valid = 1'b1;
      samp();
      chk("abort_accept", 32'(ctl()), 32'(CTL_ACC));
      tick();
      bus.i_valid = 1'b0;
      samp();
      chk("abort_decode", 32'(ctl()), 32'(CTL_NONE));
      tick();
      samp();
      chk("abort_exec", 32'(ctl()), 32'(CTL_EXF));
      tick();
      rst = 1'b1;
      samp();
      chk("abort_rst_ctl", 32'(ctl()), 32'(CTL_NONE));
      chk("abort_rst_fields", 32'({bus.o_reg0, bus.o_reg1, bus.o_dst}), 32'(0));
      tick();
      rst = 1'b0;
      last_h = -1000;
      for (int i = 0; i < 5; i++) begin
         samp();
         chk("abort_idle", 32'(ctl()), 32'(CTL_IDLE));
         tick();
      end
      run_txn(25'h0E04000, 4'b0000, 0, 1, 1'b0, saw, ns, voff, flds);
      chk("abort_no_stall", 32'(ns), 32'(0));
      chk("abort_next_exec", 32'(saw), 32'(1));

      for (int t = 0; t < 80; t++) begin
         logic [INSTR_W-1:0] ins;
         ins = mk(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)),
                  2'($urandom_range(0, 3)));
         run_txn(ins, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0) ? 1 : 0, 1'($urandom_range(0, 1)),
                 saw, ns, voff, flds);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
